seq_lock: RTL and testbench
===========================

# seq_lock

Parametrised sequential code lock. It generalises the fixed four-key A-B-C-D lock FSM to N keys, a code length of L, and a code that can be reprogrammed at run time. It adds auto-relock after a hold time and a lockout after repeated failed attempts. It sits between the debounced keypad decoder, which supplies `key_valid`/`key_id`, and the actuator driver, which consumes `unlocked`.

## Interface
- `NUM_KEYS`, 4: number of distinct keys; `KW = max(1, $clog2(NUM_KEYS))`.
- `CODE_LEN`, 4: keys per code, ≥ 2.
- `MAX_FAILS`, 3: failed attempts before lockout, ≥ 1; `FW = $clog2(MAX_FAILS+1)`.
- `UNLOCK_CYCLES`, 500: cycles `unlocked` is held before auto-relock, ≥ 1.
- `LOCKOUT_CYCLES`, 1000: cycles keys are ignored after lockout, ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_id` is valid.
- `key_id`  in  KW  index of the pressed key.
- `lock_req`  in  1  relock now (OPEN) or abort programming (PROG).
- `prog_req`  in  1  enter programming mode; honoured only in OPEN.
- `unlocked`  out  1  high in OPEN.
- `locked_out`  out  1  high in LOCKOUT.
- `prog_mode`  out  1  high in PROG.
- `prog_done`  out  1  one-cycle pulse when a new code is committed.
- `fail_count`  out  FW  failed attempts since the last success or lockout.

## Operation
- States: IDLE (with match index `idx`, 0..CODE_LEN-1), OPEN, LOCKOUT, PROG.
- Code register: CODE_LEN entries of KW bits. Reset value is `code[i] = i mod NUM_KEYS`, which gives 0,1,2,3 by default.
- IDLE, on `key_valid`:
  - If `key_id == code[idx]`: `idx++`. On the last position, go to OPEN, `idx ← 0`, `fail_count ← 0`.
  - Mismatch with `idx > 0`: this is a failed attempt. `fail_count++`. Then `idx ← 1` if `key_id == code[0]`, else `idx ← 0`; the restart key counts.
  - Mismatch with `idx == 0`: ignored; no fail is counted.
  - If the increment makes `fail_count == MAX_FAILS`: go to LOCKOUT, `idx ← 0`.
  - `key_id ≥ NUM_KEYS` is always a mismatch.
- OPEN:
  - Timer loaded with UNLOCK_CYCLES-1 on entry.
  - `key_valid` is ignored.
  - `lock_req`, or timer reaching 0, goes to IDLE.
  - `prog_req` goes to PROG. If `lock_req` and `prog_req` are both asserted, `lock_req` wins.
- LOCKOUT:
  - Timer loaded with LOCKOUT_CYCLES-1 on entry.
  - All inputs are ignored.
  - At timer 0, go to IDLE and set `fail_count ← 0`.
- PROG:
  - Each `key_valid` with `key_id < NUM_KEYS` is written to a shadow register at position `pidx`, then `pidx++`. Keys with `key_id ≥ NUM_KEYS` are ignored.
  - After the CODE_LEN-th key: shadow is copied to code, `prog_done` pulses, go to IDLE.
  - `lock_req` goes to IDLE with the code unchanged and no `prog_done`.
  - PROG has no timeout.
- Reset: state IDLE, `idx = pidx = 0`, code restored to default, timer 0. All outputs are 0.

## Timing
- Moore outputs, registered from the state register.
- `unlocked` rises on the cycle after the edge that samples the last correct key, and stays high for exactly UNLOCK_CYCLES cycles if there is no `lock_req`.
- `locked_out` is high for exactly LOCKOUT_CYCLES cycles.
- `prog_done` is high for one cycle, concurrent with the first IDLE cycle after commit. The new code is in effect from that cycle.
- `fail_count` updates one cycle after the failing key. It reads MAX_FAILS during the first LOCKOUT cycle and returns to 0 on LOCKOUT exit.
- Back-to-back `key_valid` on consecutive cycles is supported at full rate.
- `rst` asserted in any state: outputs are 0 asynchronously, and the programmed code is lost.

## Structure
- `seq_lock_pkg`: state enum `lock_state_t` (IDLE, OPEN, LOCKOUT, PROG) and the function `default_code(i)`.
- Sub-module `lock_timer`: a down-counter with load/enable and a `zero` flag. Width is `$clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES))`. It is shared by OPEN and LOCKOUT.
- Code and shadow registers, `idx`/`pidx`, and `fail_count` live in `seq_lock`.

## Test plan
- Keys 0,1,2,3 after reset: `unlocked` = 1 one cycle after the 4th key; it drops after 500 cycles.
- Keys 0,1,3: `fail_count` = 1. Then 0,1,2,3 unlocks and `fail_count` returns to 0.
- Keys 0,1,0,1,2,3: the second 0 restarts the match, `fail_count` = 1, and the sequence unlocks.
- Three failures (0,2 ×3): `locked_out` high for 1000 cycles; 0,1,2,3 during lockout does not unlock; `fail_count` = 0 after.
- Unlock, `prog_req`, keys 3,3,1,0: `prog_done` pulses; 0,1,2,3 fails; 3,3,1,0 unlocks.
- Unlock, then `lock_req` and `prog_req` together: go to IDLE, not PROG. `rst` mid-PROG: default code restored, all outputs 0.

Source files
------------

// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequential code lock.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    PROG    = 2'd3
  } lock_state_t;

  // Factory code: position i holds key (i mod num_keys), i.e. 0,1,2,3 for four keys.
  function automatic int default_code(input int i, input int num_keys = 4);
    return i % num_keys;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_lock_timer.sv
// Down-counter shared by the OPEN hold time and the LOCKOUT penalty time.
module lock_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_lock.sv
// Parametrised sequential code lock with run-time programmable code,
// auto-relock after a hold time and lockout after repeated failures.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  localparam int KW = max_int(1, $clog2(NUM_KEYS)),
  localparam int FW = $clog2(MAX_FAILS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [KW-1:0] key_id,
  input  logic          lock_req,
  input  logic          prog_req,
  output logic          unlocked,
  output logic          locked_out,
  output logic          prog_mode,
  output logic          prog_done,
  output logic [FW-1:0] fail_count
);

  localparam int IW = max_int(1, $clog2(CODE_LEN));
  localparam int TW = max_int(1, $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES)));
  localparam logic [IW-1:0] LAST        = IW'(CODE_LEN - 1);
  localparam logic [KW:0]   NK          = (KW + 1)'(NUM_KEYS);
  localparam logic [FW-1:0] FAIL_LIMIT  = FW'(MAX_FAILS);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] pidx_q, pidx_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic          done_q;
  logic          commit;
  logic [KW-1:0] code   [CODE_LEN];
  logic [KW-1:0] shadow [CODE_LEN];

  logic          key_ok, key_match, restart;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;

  // Out-of-range key indices never match and are never stored.
  assign key_ok    = ({1'b0, key_id} < NK);
  assign key_match = key_ok && (key_id == code[idx_q]);
  assign restart   = key_ok && (key_id == code[0]);
  assign fail_inc  = fail_q + 1'b1;

  lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Next-state, match/program indices, fail counter and timer control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pidx_d   = pidx_q;
    fail_d   = fail_q;
    commit   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_match) begin
            if (idx_q == LAST) begin
              state_d  = OPEN;
              idx_d    = '0;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = UNLOCK_LOAD;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (idx_q != '0) begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d  = LOCKOUT;
              idx_d    = '0;
              tmr_load = 1'b1;
              tmr_val  = LOCK_LOAD;
            end else begin
              // The key that broke the sequence may itself start a new attempt.
              idx_d = restart ? IW'(1) : '0;
            end
          end
        end
      end
      OPEN: begin
        if (lock_req || tmr_zero) begin
          state_d = IDLE;
        end else if (prog_req) begin
          state_d = PROG;
          pidx_d  = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      PROG: begin
        if (lock_req) begin
          state_d = IDLE;
          pidx_d  = '0;
        end else if (key_valid && key_ok) begin
          if (pidx_q == LAST) begin
            commit  = 1'b1;
            state_d = IDLE;
            pidx_d  = '0;
          end else begin
            pidx_d = pidx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pidx_q  <= '0;
      fail_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      fail_q  <= fail_d;
      done_q  <= commit;
    end
  end

  // Shadow collects the new code; contents only matter once fully written.
  always_ff @(posedge clk) begin
    if ((state_q == PROG) && !lock_req && key_valid && key_ok)
      shadow[pidx_q] <= key_id;
  end

  // Active code; the final programming key bypasses the shadow on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CODE_LEN; i++)
        code[i] <= KW'(default_code(i, NUM_KEYS));
    end else if (commit) begin
      for (int i = 0; i < CODE_LEN; i++)
        code[i] <= (IW'(i) == pidx_q) ? key_id : shadow[i];
    end
  end

  assign unlocked   = (state_q == OPEN);
  assign locked_out = (state_q == LOCKOUT);
  assign prog_mode  = (state_q == PROG);
  assign prog_done  = done_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_seq_lock.sv
// Directed bench for seq_lock with an expected-output scoreboard.
module tb_seq_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [1:0] key_id;
  logic       lock_req;
  logic       prog_req;
  logic       unlocked;
  logic       locked_out;
  logic       prog_mode;
  logic       prog_done;
  logic [1:0] fail_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       u;
    logic       lo;
    logic       pm;
    logic       pd;
    logic [1:0] fc;
  } exp_t;

  exp_t sb[$];

  seq_lock dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_id     (key_id),
    .lock_req   (lock_req),
    .prog_req   (prog_req),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .prog_done  (prog_done),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic u, input logic lo,
                      input logic pm, input logic pd, input logic [1:0] fc);
    exp_t e;
    e.tag = tag; e.u = u; e.lo = lo; e.pm = pm; e.pd = pd; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".unlocked"},   unlocked,   e.u);
      chk({e.tag, ".locked_out"}, locked_out, e.lo);
      chk({e.tag, ".prog_mode"},  prog_mode,  e.pm);
      chk({e.tag, ".prog_done"},  prog_done,  e.pd);
      chk({e.tag, ".fail_count"}, fail_count, e.fc);
    end
  endtask

  task automatic expect_out(input string tag, input logic u, input logic lo,
                            input logic pm, input logic pd, input logic [1:0] fc);
    push(tag, u, lo, pm, pd, fc);
    check_sb();
  endtask

  task automatic press(input logic [1:0] k);
    key_valid = 1'b1;
    key_id    = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic press4(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic pulse(input bit lk, input bit pg);
    lock_req = lk;
    prog_req = pg;
    @(posedge clk); #1;
    lock_req = 1'b0;
    prog_req = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; key_valid = 1'b0; key_id = '0; lock_req = 1'b0; prog_req = 1'b0;
    @(posedge clk); #1;
    expect_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Default code and auto-relock hold time
    press(0); press(1); press(2);
    expect_out("partial", 0, 0, 0, 0, 0);
    press(3);
    expect_out("open_default", 1, 0, 0, 0, 0);
    cnt = 1;
    for (int i = 0; i < 2000 && unlocked; i++) begin
      @(posedge clk); #1;
      if (unlocked) cnt++;
    end
    chk("unlock_hold_cycles", cnt, 500);
    expect_out("auto_relock", 0, 0, 0, 0, 0);

    // One failure, then success clears the count
    press(0); press(1); press(3);
    expect_out("one_fail", 0, 0, 0, 0, 1);
    press4(0, 1, 2, 3);
    expect_out("open_after_fail", 1, 0, 0, 0, 0);
    pulse(1, 0);
    expect_out("lock_req_relock", 0, 0, 0, 0, 0);

    // Restart key counts as the first key of a new attempt
    press(0); press(1); press(0);
    expect_out("restart_fail", 0, 0, 0, 0, 1);
    press(1); press(2); press(3);
    expect_out("restart_open", 1, 0, 0, 0, 0);
    pulse(1, 0);

    // Lockout after three failures
    press(0); press(2);
    expect_out("fail1", 0, 0, 0, 0, 1);
    press(0); press(2);
    expect_out("fail2", 0, 0, 0, 0, 2);
    press(0); press(2);
    expect_out("lockout_enter", 0, 1, 0, 0, 3);
    cnt = 1;
    press(0); if (locked_out) cnt++;
    press(1); if (locked_out) cnt++;
    press(2); if (locked_out) cnt++;
    press(3); if (locked_out) cnt++;
    expect_out("lockout_ignores_keys", 0, 1, 0, 0, 3);
    for (int i = 0; i < 3000 && locked_out; i++) begin
      @(posedge clk); #1;
      if (locked_out) cnt++;
    end
    chk("lockout_cycles", cnt, 1000);
    expect_out("lockout_exit", 0, 0, 0, 0, 0);

    // Programming aborted by lock_req keeps the old code
    press4(0, 1, 2, 3);
    expect_out("open_for_abort", 1, 0, 0, 0, 0);
    pulse(0, 1);
    expect_out("prog_enter", 0, 0, 1, 0, 0);
    press(1); press(1);
    pulse(1, 0);
    expect_out("prog_abort", 0, 0, 0, 0, 0);
    press4(0, 1, 2, 3);
    expect_out("old_code_kept", 1, 0, 0, 0, 0);

    // Program 3,3,1,0
    pulse(0, 1);
    press(3); press(3); press(1);
    expect_out("prog_partial", 0, 0, 1, 0, 0);
    press(0);
    expect_out("prog_commit", 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    expect_out("prog_done_pulse_end", 0, 0, 0, 0, 0);
    press4(3, 3, 1, 0);
    expect_out("new_code_open", 1, 0, 0, 0, 0);
    pulse(1, 0);
    press4(0, 1, 2, 3);
    expect_out("old_code_rejected", 0, 0, 0, 0, 0);
    press(0);
    expect_out("partial_new_fail", 0, 0, 0, 0, 1);
    press4(3, 3, 1, 0);
    expect_out("new_code_open2", 1, 0, 0, 0, 0);

    // lock_req beats prog_req
    pulse(1, 1);
    expect_out("lock_beats_prog", 0, 0, 0, 0, 0);

    // Reset in the middle of programming restores the default code
    press4(3, 3, 1, 0);
    pulse(0, 1);
    press(2); press(2);
    expect_out("prog_midway", 0, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    press4(3, 3, 1, 0);
    expect_out("prog_code_lost", 0, 0, 0, 0, 0);
    press(0);
    press4(0, 1, 2, 3);
    expect_out("default_restored", 1, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
